// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  localparam int INSTR_BYTES = 4;
  localparam int ENTRY_AW    = 32;
  localparam int ENTRY_IW    = 32;

  // Default entry layout; the controller passes its own width-matched type to the FIFO.
  typedef struct packed {
    logic [ENTRY_AW-1:0] pc;
    logic [ENTRY_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of fetch entries with synchronous flush; head is read from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  input  logic   flush,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC register, run/error FSM and prefetch FIFO feeding decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     INSTR_WIDTH   = 32,
  parameter int                     MEM_BYTES     = 4096,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
  parameter int                     DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [INSTR_WIDTH-1:0]   mem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_WIDTH-1:0]   instr_data,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     fetch_err,
  output logic [ADDRESS_WIDTH-1:0] err_pc
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0]   instr;
  } entry_t;

  // Highest PC whose whole word still lies inside memory.
  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(MEM_BYTES - INSTR_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] STEP    = ADDRESS_WIDTH'(INSTR_BYTES);

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic                     pc_ok, redirect_bad;
  logic                     push, pop, fifo_full, fifo_empty;
  logic                     err_load;
  logic [ADDRESS_WIDTH-1:0] err_val;
  entry_t                   wr_entry, head;

  assign mem_addr     = fetch_pc;
  assign pc_ok        = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state == RUN) && !redirect_valid && pc_ok && (!fifo_full || pop);

  assign wr_entry = '{pc: fetch_pc, instr: mem_rdata};

  always_comb begin
    state_nxt = state;
    err_load  = 1'b0;
    err_val   = fetch_pc;
    if (redirect_valid) begin
      if (redirect_bad) begin
        state_nxt = ERR;
        err_load  = 1'b1;
        err_val   = redirect_pc;
      end else begin
        state_nxt = enable ? RUN : IDLE;
      end
    end else begin
      case (state)
        IDLE: if (enable) state_nxt = RUN;
        RUN: begin
          if (!pc_ok) begin
            state_nxt = ERR;
            err_load  = 1'b1;
          end else if (!enable) begin
            state_nxt = IDLE;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      err_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (push)      fetch_pc <= fetch_pc + STEP;
      if (err_load) err_pc <= err_val;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;
  assign fetch_err   = (state == ERR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs driven and outputs checked on the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_err;
  logic [31:0] err_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word encodes its own address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ {16'h0, a[15:0]};
  endfunction

  assign mem_rdata = word(mem_addr);

  fetch_ctrl #(
    .ADDRESS_WIDTH (32),
    .INSTR_WIDTH   (32),
    .MEM_BYTES     (4096),
    .RESET_PC      (32'h0),
    .DEPTH         (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err),
    .err_pc         (err_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_data"}, instr_data, word(pc));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_errpc", err_pc, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);

    // 1: streaming fetch, first word visible two edges after enable
    rst_n       = 1'b1;
    enable      = 1'b1;
    instr_ready = 1'b1;
    cyc();
    chk("t1_first_idle", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_head("t1_stream", 32'(4 * i));
    end

    // 2: backpressure fills the FIFO and stalls the PC
    instr_ready = 1'b0;
    enable      = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk_head("t2_hold", 32'h0);
    chk("t2_stall_addr", mem_addr, 32'h8);
    instr_ready = 1'b1;
    cyc();
    chk_head("t2_rel4", 32'h4);
    cyc();
    chk_head("t2_rel8", 32'h8);
    chk("t2_addr", mem_addr, 32'h10);

    // 3: redirect flushes PCs 8 and 12
    redirect(32'h40);
    chk("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_addr", mem_addr, 32'h40);
    cyc();
    chk_head("t3_first", 32'h40);
    cyc();
    chk_head("t3_second", 32'h44);

    // 4: misaligned redirect, then recovery
    redirect(32'h42);
    chk("t4_err", {31'b0, fetch_err}, 32'd1);
    chk("t4_errpc", err_pc, 32'h42);
    chk("t4_valid", {31'b0, instr_valid}, 32'd0);
    cyc();
    chk("t4_sticky", {31'b0, fetch_err}, 32'd1);
    chk("t4_nopush", {31'b0, instr_valid}, 32'd0);
    redirect(32'h80);
    chk("t4_clear", {31'b0, fetch_err}, 32'd0);
    cyc();
    chk_head("t4_resume", 32'h80);

    // 5: last in-range words, then range error at 0x1000
    redirect(32'hFF8);
    chk("t5_err0", {31'b0, fetch_err}, 32'd0);
    cyc();
    chk_head("t5_ff8", 32'hFF8);
    cyc();
    chk_head("t5_ffc", 32'hFFC);
    chk("t5_noerr_yet", {31'b0, fetch_err}, 32'd0);
    cyc();
    chk("t5_err", {31'b0, fetch_err}, 32'd1);
    chk("t5_errpc", err_pc, 32'h1000);
    chk("t5_none", {31'b0, instr_valid}, 32'd0);
    cyc();
    chk("t5_none2", {31'b0, instr_valid}, 32'd0);

    // 6: asynchronous reset mid-stream
    redirect(32'h100);
    cyc();
    chk_head("t6_run", 32'h100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_async_err", {31'b0, fetch_err}, 32'd0);
    chk("t6_async_addr", mem_addr, 32'h0);
    chk("t6_async_errpc", err_pc, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_restart_idle", {31'b0, instr_valid}, 32'd0);
    cyc();
    chk_head("t6_restart0", 32'h0);
    cyc();
    chk_head("t6_restart4", 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the byte-addressed, combinational-read instruction memory.
- Owns the fetch PC and drives the memory address each cycle.
- Captures the returned 32-bit word together with its PC into a small prefetch FIFO, which presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects, misaligned targets and out-of-range fetches.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, instruction word width.
- MEM_BYTES, 4096, instruction memory size in bytes; a fetch at or beyond MEM_BYTES-3 is out of range.
- RESET_PC, 0, PC loaded at reset.
- DEPTH, 2, prefetch FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  run request; fetching occurs only while high.
- mem_addr  out  ADDRESS_WIDTH  byte address to instruction memory; equals fetch_pc combinationally.
- mem_rdata  in  INSTR_WIDTH  instruction word from memory, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  ADDRESS_WIDTH  new fetch target.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  INSTR_WIDTH  head instruction word.
- instr_pc  out  ADDRESS_WIDTH  PC of the head instruction.
- fetch_err  out  1  high while in ERR state.
- err_pc  out  ADDRESS_WIDTH  offending PC, captured on entry to ERR.

Behaviour:
- Reset values (async):
  - fetch_pc=RESET_PC, state=IDLE, FIFO count/pointers=0, entry storage=0.
  - instr_valid=0, fetch_err=0, err_pc=0.
  - mem_addr therefore equals RESET_PC.
- States and transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - Any state -> ERR on the error conditions below.
  - ERR -> RUN on a redirect with a valid target and enable=1, or ERR -> IDLE on such a redirect with enable=0.
  - ERR is otherwise sticky.
- Push:
  - Condition: state==RUN, no redirect this cycle, fetch_pc in range and aligned, and space available (count<DEPTH, or count==DEPTH with a pop this cycle).
  - Action: write {fetch_pc, mem_rdata} at the tail, then fetch_pc <= fetch_pc+4.
  - PC arithmetic wraps modulo 2^ADDRESS_WIDTH.
- Pop: instr_valid && instr_ready advances the head. Push and pop may occur in the same cycle; count is unchanged.
- Output latency: a word fetched in cycle N is visible on instr_data/instr_pc in cycle N+1. Outputs are registered FIFO head, with no combinational path from mem_rdata to instr_data.
- Redirect (highest priority):
  - Flush the FIFO: count=0, pointers reset, instr_valid=0 next cycle.
  - Any pop in that same cycle is ignored.
  - fetch_pc <= redirect_pc. No push occurs in the redirect cycle.
  - If redirect_pc[1:0]!=0 or redirect_pc>MEM_BYTES-4: enter ERR with err_pc=redirect_pc. fetch_pc is still loaded.
- Range error: in RUN, if fetch_pc>MEM_BYTES-4, there is no push. Enter ERR with err_pc=fetch_pc.
- In ERR:
  - No pushes.
  - Entries already in the FIFO remain poppable, since they precede the fault in program order.
- IDLE: no pushes, and the FIFO drains normally. Re-entering RUN resumes at the held fetch_pc.
- Reset mid-operation discards all state immediately, independent of the clock.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, ERR}.
  - Constant INSTR_BYTES=4.
  - packed struct fetch_entry_t {pc, instr}.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty and the same async active-low reset.
- fetch_ctrl contains the FSM, PC register and error capture.

Test Plan:
1. Reset, then enable=1, instr_ready=1, memory holding words W0..W3 at 0..12 -> instr_valid rises in cycle 2, with instr_pc 0,4,8,12 on consecutive cycles and data W0..W3.
2. Backpressure: instr_ready=0 for 5 cycles after enable -> FIFO holds PCs 0,4 (count=2) and mem_addr stalls at 8. After release, PCs 0,4,8 appear in order, none lost or duplicated.
3. Redirect to 0x40 while FIFO holds PCs 8,12 and instr_ready=1 -> next cycle instr_valid=0. First instruction out is PC 0x40, and neither PC 8 nor PC 12 reaches decode.
4. Redirect to 0x42 -> fetch_err=1 and err_pc=0x42 next cycle, with no further pushes. A subsequent redirect to 0x80 -> fetch_err=0 and instructions resume from 0x80.
5. Redirect to 0xFF8 with MEM_BYTES=4096 -> PCs 0xFF8 and 0xFFC are delivered. Then fetch_err=1 with err_pc=0x1000, and no instruction is delivered for PC 0x1000.
6. Assert rst_n=0 asynchronously mid-stream (between edges) -> instr_valid=0, fetch_err=0 and mem_addr=RESET_PC immediately. After rst_n=1 with enable=1, fetching restarts at RESET_PC.
